// File: rtl/pipelined_ripple_carry_addr.sv
// WIDTH-bit adder cut into STAGES registered ripple slices with valid/ready backpressure.
// Optional `define ADDR_OVF_EN adds a registered signed-overflow output (ovf).
module pipelined_ripple_carry_addr #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout
`ifdef ADDR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SN = (STAGES >= 1) ? STAGES : 1;
  localparam int S  = WIDTH / SN;
  localparam int L  = SN - 1;

  if (STAGES < 1 || (WIDTH % SN) != 0) begin : g_param_check
    $fatal(1, "pipelined_ripple_carry_addr: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             valid_q [SN];
  logic             carry_q [SN];
  logic [WIDTH-1:0] a_q     [SN];
  logic [WIDTH-1:0] b_q     [SN];
  logic [WIDTH-1:0] sum_q   [SN];

  logic [SN-1:0]    adv;
  logic             nxt_v   [SN];
  logic             nxt_c   [SN];
  logic [WIDTH-1:0] nxt_a   [SN];
  logic [WIDTH-1:0] nxt_b   [SN];
  logic [WIDTH-1:0] nxt_sum [SN];

  // Advance enables ripple back from the output; each slice adds its S bits onto the
  // partial sum handed over by the previous stage, operands travel forward unchanged.
  always_comb begin
    logic             run;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] ps;
    logic             pc;
    logic [S:0]       t;
    run = out_ready;
    for (int k = L; k >= 0; k--) begin
      run    = !valid_q[k] || run;
      adv[k] = run;
    end
    for (int k = 0; k < SN; k++) begin
      if (k == 0) begin
        pa       = in1;
        pb       = in2;
        ps       = '0;
        pc       = cin;
        nxt_v[k] = in_valid;
      end else begin
        pa       = a_q[(k > 0) ? k - 1 : 0];
        pb       = b_q[(k > 0) ? k - 1 : 0];
        ps       = sum_q[(k > 0) ? k - 1 : 0];
        pc       = carry_q[(k > 0) ? k - 1 : 0];
        nxt_v[k] = valid_q[(k > 0) ? k - 1 : 0];
      end
      t = {1'b0, pa[k*S +: S]} + {1'b0, pb[k*S +: S]} + {{S{1'b0}}, pc};
      ps[k*S +: S] = t[S-1:0];
      nxt_a[k]   = pa;
      nxt_b[k]   = pb;
      nxt_sum[k] = ps;
      nxt_c[k]   = t[S];
    end
  end

  // A stage only loads when it advances, so a stalled stage keeps every bit it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SN; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < SN; k++) begin
        if (adv[k]) begin
          valid_q[k] <= nxt_v[k];
          carry_q[k] <= nxt_c[k];
          a_q[k]     <= nxt_a[k];
          b_q[k]     <= nxt_b[k];
          sum_q[k]   <= nxt_sum[k];
        end
      end
    end
  end

`ifdef ADDR_OVF_EN
  logic ovf_q;

  // Overflow is resolved as the last slice loads, using the operand MSBs carried this far.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv[L]) begin
      ovf_q <= (nxt_a[L][WIDTH-1] == nxt_b[L][WIDTH-1]) &&
               (nxt_sum[L][WIDTH-1] != nxt_a[L][WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = adv[0];
  assign out_valid = valid_q[L];
  assign out       = sum_q[L];
  assign cout      = carry_q[L];

endmodule

// File: tb/tb_pipelined_ripple_carry_addr.sv
// Directed bench for pipelined_ripple_carry_addr: 64/4 main instance plus a 16-bit stage sweep.
// Checks ovf as well when compiled with `define ADDR_OVF_EN.
module tb_pipelined_ripple_carry_addr;

  localparam int W = 64;
  localparam int N = 1000;
  localparam int SW_ST [4] = '{1, 2, 4, 16};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          cout;
`ifdef ADDR_OVF_EN
  logic          ovf;
  logic [3:0]    sw_ovf;
`endif

  logic          sw_valid;
  logic          sw_ready;
  logic          sw_cin;
  logic [15:0]   sw_in1;
  logic [15:0]   sw_in2;
  logic [3:0]    sw_in_ready;
  logic [3:0]    sw_out_valid;
  logic [3:0]    sw_cout;
  logic [15:0]   sw_out [4];
  logic [16:0]   hist [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_ripple_carry_addr #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout)
`ifdef ADDR_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_ripple_carry_addr #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[0]),
    .in1(sw_in1), .in2(sw_in2), .cin(sw_cin), .out_valid(sw_out_valid[0]),
    .out_ready(sw_ready), .out(sw_out[0]), .cout(sw_cout[0])
`ifdef ADDR_OVF_EN
    , .ovf(sw_ovf[0])
`endif
  );

  pipelined_ripple_carry_addr #(.WIDTH(16), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[1]),
    .in1(sw_in1), .in2(sw_in2), .cin(sw_cin), .out_valid(sw_out_valid[1]),
    .out_ready(sw_ready), .out(sw_out[1]), .cout(sw_cout[1])
`ifdef ADDR_OVF_EN
    , .ovf(sw_ovf[1])
`endif
  );

  pipelined_ripple_carry_addr #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[2]),
    .in1(sw_in1), .in2(sw_in2), .cin(sw_cin), .out_valid(sw_out_valid[2]),
    .out_ready(sw_ready), .out(sw_out[2]), .cout(sw_cout[2])
`ifdef ADDR_OVF_EN
    , .ovf(sw_ovf[2])
`endif
  );

  pipelined_ripple_carry_addr #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[3]),
    .in1(sw_in1), .in2(sw_in2), .cin(sw_cin), .out_valid(sw_out_valid[3]),
    .out_ready(sw_ready), .out(sw_out[3]), .cout(sw_cout[3])
`ifdef ADDR_OVF_EN
    , .ovf(sw_ovf[3])
`endif
  );

  // Presents one add on an empty pipe and waits (bounded) for its result; lat=-1 on timeout.
  task automatic send_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               output logic [W-1:0] o, output logic co, output logic ov,
                               output int lat);
    int guard;
    @(negedge clk);
    in1 = a; in2 = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    o  = out;
    co = cout;
`ifdef ADDR_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    logic [W-1:0] o; logic co; logic ov; int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0; cin = 1'b0;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_in1 = '0; sw_in2 = '0; sw_cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, cout, out} !== {2'b00, 64'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b cout=%b out=%h, want 0/0/0", out_valid, cout, out);
    end
`ifdef ADDR_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b, want 0", ovf);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    send_and_wait(64'd414, 64'd1036, 1'b0, o, co, ov, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL first_latency: got %0d, want 4", lat);
    end
    checks++;
    if ({co, o} !== {1'b0, 64'd1450}) begin
      errors++;
      $display("[TB] FAIL first_sum: got cout=%b out=%0d, want cout=0 out=1450", co, o);
    end
  endtask

  task automatic test_carry_ripple();
    logic [W-1:0] o; logic co; logic ov; int lat;
    send_and_wait(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, o, co, ov, lat);
    checks++;
    if (lat !== 4 || {co, o} !== {1'b1, 64'd0}) begin
      errors++;
      $display("[TB] FAIL carry_ripple: got lat=%0d cout=%b out=%h, want lat=4 cout=1 out=0", lat, co, o);
    end
`ifdef ADDR_OVF_EN
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("[TB] FAIL carry_ripple_ovf: got %b, want 0", ov);
    end
`endif
  endtask

  task automatic test_overflow();
    logic [W-1:0] o; logic co; logic ov; int lat;
    send_and_wait(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, o, co, ov, lat);
    checks++;
    if (lat !== 4 || {co, o} !== {1'b1, 64'd0}) begin
      errors++;
      $display("[TB] FAIL neg_overflow: got lat=%0d cout=%b out=%h, want lat=4 cout=1 out=0", lat, co, o);
    end
`ifdef ADDR_OVF_EN
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("[TB] FAIL neg_overflow_ovf: got %b, want 1", ov);
    end
`endif
    send_and_wait(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, o, co, ov, lat);
    checks++;
    if (lat !== 4 || {co, o} !== {1'b0, 64'h8000_0000_0000_0000}) begin
      errors++;
      $display("[TB] FAIL pos_overflow: got lat=%0d cout=%b out=%h, want lat=4 cout=0 out=8000000000000000", lat, co, o);
    end
`ifdef ADDR_OVF_EN
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pos_overflow_ovf: got %b, want 1", ov);
    end
`endif
  endtask

  // Ten back-to-back adds with out_ready low in cycles 6-9; results checked in order.
  task automatic test_back_to_back();
    logic [64:0]  expq [$];
    logic [64:0]  want;
    logic [W-1:0] a, b;
    logic         c;
    int           sent, recv;
    sent = 0; recv = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'(($urandom));
    for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 9);
      if (sent < 10) begin
        in_valid = 1'b1; in1 = a; in2 = b; cin = c;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sent < 10) begin
        checks++;
        if (in_ready !== !(cyc >= 6 && cyc <= 9)) begin
          errors++;
          $display("[TB] FAIL bp_in_ready cycle %0d: got %b, want %b", cyc, in_ready, !(cyc >= 6 && cyc <= 9));
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_extra_output: got out=%h with nothing outstanding, want none", out);
        end else begin
          want = expq.pop_front();
          if ({cout, out} !== want) begin
            errors++;
            $display("[TB] FAIL bp_result %0d: got %h, want %h", recv, {cout, out}, want);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back({1'b0, a} + {1'b0, b} + {64'd0, c});
        sent++;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'(($urandom));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 10 || expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d results (%0d left), want 10 (0 left)", recv, expq.size());
    end
  endtask

  task automatic test_midflight_reset();
    logic [W-1:0] o; logic co; logic ov; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in1 = 64'd100 + 64'(i); in2 = 64'd7; cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_quiet cycle %0d: got out_valid=%b, want 0", i, out_valid);
      end
    end
    send_and_wait(64'd5045, 64'd45042, 1'b0, o, co, ov, lat);
    checks++;
    if (lat !== 4 || {co, o} !== {1'b0, 64'd50087}) begin
      errors++;
      $display("[TB] FAIL midreset_add: got lat=%0d cout=%b out=%0d, want lat=4 cout=0 out=50087", lat, co, o);
    end
  endtask

  // Streams N adds into four 16-bit instances; result j must appear exactly STAGES cycles later.
  task automatic test_sweep();
    int j;
    logic [15:0] a, b;
    logic c;
    @(negedge clk);
    rst = 1'b1; sw_valid = 1'b0; sw_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < N + 18; t++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        j = t - SW_ST[i];
        checks++;
        if (j >= 0 && j < N) begin
          if (sw_out_valid[i] !== 1'b1 || {sw_cout[i], sw_out[i]} !== hist[j]) begin
            errors++;
            $display("[TB] FAIL sweep_s%0d idx %0d: got valid=%b sum=%h, want valid=1 sum=%h",
                     SW_ST[i], j, sw_out_valid[i], {sw_cout[i], sw_out[i]}, hist[j]);
          end
        end else if (sw_out_valid[i] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL sweep_s%0d idle t=%0d: got valid=%b, want 0", SW_ST[i], t, sw_out_valid[i]);
        end
      end
      checks++;
      if (sw_in_ready !== 4'hF) begin
        errors++;
        $display("[TB] FAIL sweep_in_ready t=%0d: got %b, want 1111", t, sw_in_ready);
      end
      if (t < N) begin
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
        hist[t] = {1'b0, a} + {1'b0, b} + {16'd0, c};
        sw_in1 = a; sw_in2 = b; sw_cin = c; sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_midflight_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
